// File: rtl/icache_dm.sv
// Direct-mapped read-only instruction cache with a single-line refill FSM.
// Lookup is combinational. Misses are captured only while the FSM is idle.
module icache_dm #(
  parameter int          LINES      = 16,
  parameter int          LINE_WORDS = 4,
  parameter logic [31:0] IMEM_LIMIT = 32'h0001_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] i_addr,
  input  logic        i_rd,
  input  logic [2:0]  i_trd,
  output logic [31:0] i_rd_data,
  output logic        i_miss,
  output logic        i_segfault,
  input  logic        flush,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        fill_done,
  output logic [2:0]  fill_trd,
  output logic        busy,
  output logic [15:0] hit_cnt,
  output logic [15:0] miss_cnt
);
  localparam int OB = $clog2(LINE_WORDS);
  localparam int IB = $clog2(LINES);
  localparam int TW = 32 - OB - 2 - IB;

  typedef enum logic [1:0] {IDLE, REQ, FILL, DONE} state_t;

  state_t            state_q, state_d;
  logic [LINES-1:0]  valid_q, valid_d;
  logic [TW-1:0]     tag_q  [LINES];
  logic [TW-1:0]     tag_d  [LINES];
  logic [31:0]       data_q [LINES][LINE_WORDS];
  logic [31:0]       data_d [LINES][LINE_WORDS];
  logic [OB-1:0]     beat_q, beat_d;
  logic [31:0]       mem_addr_q, mem_addr_d;
  logic [2:0]        fill_trd_q, fill_trd_d;
  logic              flush_seen_q, flush_seen_d;
  logic [15:0]       hit_cnt_q, hit_cnt_d;
  logic [15:0]       miss_cnt_q, miss_cnt_d;

  logic [OB-1:0] off;
  logic [IB-1:0] idx, fill_idx;
  logic [TW-1:0] tag, fill_tag;
  logic          seg, hit, miss;

  assign off      = i_addr[OB+1:2];
  assign idx      = i_addr[OB+IB+1:OB+2];
  assign tag      = i_addr[31:OB+IB+2];
  // The captured line address doubles as the fill index/tag holder.
  assign fill_idx = mem_addr_q[OB+IB+1:OB+2];
  assign fill_tag = mem_addr_q[31:OB+IB+2];

  assign seg  = i_rd & ((i_addr >= IMEM_LIMIT) | (i_addr[1:0] != 2'b00));
  assign hit  = i_rd & ~seg & valid_q[idx] & (tag_q[idx] == tag);
  assign miss = i_rd & ~seg & ~hit;

  assign i_rd_data  = hit ? data_q[idx][off] : 32'h0;
  assign i_miss     = miss;
  assign i_segfault = seg;
  assign mem_req    = (state_q == REQ);
  assign mem_addr   = mem_addr_q;
  assign fill_done  = (state_q == DONE);
  assign fill_trd   = fill_trd_q;
  assign busy       = (state_q != IDLE);
  assign hit_cnt    = hit_cnt_q;
  assign miss_cnt   = miss_cnt_q;

  always_comb begin
    state_d      = state_q;
    valid_d      = valid_q;
    tag_d        = tag_q;
    data_d       = data_q;
    beat_d       = beat_q;
    mem_addr_d   = mem_addr_q;
    fill_trd_d   = fill_trd_q;
    flush_seen_d = flush_seen_q | flush;
    hit_cnt_d    = hit_cnt_q;
    miss_cnt_d   = miss_cnt_q;

    if (hit && hit_cnt_q != 16'hFFFF) hit_cnt_d = hit_cnt_q + 16'd1;

    unique case (state_q)
      IDLE: if (miss) begin
        mem_addr_d   = {i_addr[31:OB+2], {(OB+2){1'b0}}};
        fill_trd_d   = i_trd;
        valid_d[idx] = 1'b0;
        flush_seen_d = flush;
        if (miss_cnt_q != 16'hFFFF) miss_cnt_d = miss_cnt_q + 16'd1;
        state_d      = REQ;
      end
      REQ: if (mem_gnt) begin
        beat_d  = '0;
        state_d = FILL;
      end
      FILL: if (mem_rvalid) begin
        data_d[fill_idx][beat_q] = mem_rdata;
        beat_d = beat_q + 1'b1;
        if (beat_q == OB'(LINE_WORDS - 1)) state_d = DONE;
      end
      DONE: begin
        tag_d[fill_idx]   = fill_tag;
        valid_d[fill_idx] = ~(flush_seen_q | flush);
        state_d           = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Flush overrides any valid bit set or cleared above.
    if (flush) valid_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      valid_q      <= '0;
      beat_q       <= '0;
      mem_addr_q   <= '0;
      fill_trd_q   <= '0;
      flush_seen_q <= 1'b0;
      hit_cnt_q    <= '0;
      miss_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      beat_q       <= beat_d;
      mem_addr_q   <= mem_addr_d;
      fill_trd_q   <= fill_trd_d;
      flush_seen_q <= flush_seen_d;
      hit_cnt_q    <= hit_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end
endmodule
